// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and load/store.
// MEM has fixed priority, bounded by a streak limit so a waiting fetch is always served.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned TIMEOUT         = 255
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                inst_req_in,
    input  logic [ADDR_W-1:0]   inst_addr_in,
    output logic [DATA_W-1:0]   inst_rdata_out,
    output logic                inst_done_out,
    output logic                inst_stall_out,

    input  logic                data_req_in,
    input  logic                data_we_in,
    input  logic [DATA_W/8-1:0] data_be_in,
    input  logic [ADDR_W-1:0]   data_addr_in,
    input  logic [DATA_W-1:0]   data_wdata_in,
    output logic [DATA_W-1:0]   data_rdata_out,
    output logic                data_done_out,
    output logic                data_stall_out,

    output logic                mem_req_out,
    output logic                mem_we_out,
    output logic [DATA_W/8-1:0] mem_be_out,
    output logic [ADDR_W-1:0]   mem_addr_out,
    output logic [DATA_W-1:0]   mem_wdata_out,
    input  logic                mem_ack_in,
    input  logic [DATA_W-1:0]   mem_rdata_in,

    output logic                err_out
);

    localparam logic [3:0] StreakMax = 4'(MAX_DATA_STREAK);
    localparam bit         ToutEn    = (TIMEOUT != 0);
    localparam logic [7:0] ToutLast  = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDataBusy,
        StInstBusy
    } state_e;

    state_e      state_q;
    logic [3:0]  streak_q;
    logic [7:0]  tout_q;

    logic inst_vld;
    logic data_vld;
    logic grant_data;
    logic tout_hit;

    // A requester completing this cycle is not re-arbitrated until its done pulse has passed.
    assign inst_vld   = inst_req_in & ~inst_done_out;
    assign data_vld   = data_req_in & ~data_done_out;
    assign grant_data = data_vld & ~((streak_q == StreakMax) & inst_vld);
    assign tout_hit   = ToutEn && (tout_q == ToutLast);

    assign inst_stall_out = inst_vld;
    assign data_stall_out = data_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            streak_q       <= '0;
            tout_q         <= '0;
            inst_rdata_out <= '0;
            inst_done_out  <= 1'b0;
            data_rdata_out <= '0;
            data_done_out  <= 1'b0;
            mem_req_out    <= 1'b0;
            mem_we_out     <= 1'b0;
            mem_be_out     <= '0;
            mem_addr_out   <= '0;
            mem_wdata_out  <= '0;
            err_out        <= 1'b0;
        end else begin
            inst_done_out <= 1'b0;
            data_done_out <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_data) begin
                        state_q       <= StDataBusy;
                        mem_req_out   <= 1'b1;
                        mem_we_out    <= data_we_in;
                        mem_be_out    <= data_we_in ? data_be_in : '1;
                        mem_addr_out  <= data_addr_in;
                        mem_wdata_out <= data_wdata_in;
                        if (!inst_req_in) begin
                            streak_q <= '0;
                        end else if (streak_q != StreakMax) begin
                            streak_q <= streak_q + 4'd1;
                        end
                    end else if (inst_vld) begin
                        state_q       <= StInstBusy;
                        mem_req_out   <= 1'b1;
                        mem_we_out    <= 1'b0;
                        mem_be_out    <= '1;
                        mem_addr_out  <= inst_addr_in;
                        mem_wdata_out <= '0;
                        streak_q      <= '0;
                    end
                end
                StDataBusy, StInstBusy: begin
                    if (mem_ack_in || tout_hit) begin
                        // An ack in the timeout cycle takes precedence over the abort.
                        state_q     <= StIdle;
                        mem_req_out <= 1'b0;
                        tout_q      <= '0;
                        if (!mem_ack_in) begin
                            err_out <= 1'b1;
                        end
                        if (state_q == StDataBusy) begin
                            data_done_out  <= 1'b1;
                            data_rdata_out <= mem_ack_in ? mem_rdata_in : '0;
                        end else begin
                            inst_done_out  <= 1'b1;
                            inst_rdata_out <= mem_ack_in ? mem_rdata_in : '0;
                        end
                    end else begin
                        tout_q <= tout_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a cycle-level behavioural reference model.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned BW   = DW / 8;
    localparam int unsigned MAXS = 4;
    localparam int unsigned TOUT = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          inst_req_in = 1'b0;
    logic [AW-1:0] inst_addr_in = '0;
    logic [DW-1:0] inst_rdata_out;
    logic          inst_done_out;
    logic          inst_stall_out;
    logic          data_req_in = 1'b0;
    logic          data_we_in = 1'b0;
    logic [BW-1:0] data_be_in = '0;
    logic [AW-1:0] data_addr_in = '0;
    logic [DW-1:0] data_wdata_in = '0;
    logic [DW-1:0] data_rdata_out;
    logic          data_done_out;
    logic          data_stall_out;
    logic          mem_req_out;
    logic          mem_we_out;
    logic [BW-1:0] mem_be_out;
    logic [AW-1:0] mem_addr_out;
    logic [DW-1:0] mem_wdata_out;
    logic          mem_ack_in = 1'b0;
    logic [DW-1:0] mem_rdata_in = '0;
    logic          err_out;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .MAX_DATA_STREAK(MAXS),
        .TIMEOUT        (TOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inst_req_in   (inst_req_in),
        .inst_addr_in  (inst_addr_in),
        .inst_rdata_out(inst_rdata_out),
        .inst_done_out (inst_done_out),
        .inst_stall_out(inst_stall_out),
        .data_req_in   (data_req_in),
        .data_we_in    (data_we_in),
        .data_be_in    (data_be_in),
        .data_addr_in  (data_addr_in),
        .data_wdata_in (data_wdata_in),
        .data_rdata_out(data_rdata_out),
        .data_done_out (data_done_out),
        .data_stall_out(data_stall_out),
        .mem_req_out   (mem_req_out),
        .mem_we_out    (mem_we_out),
        .mem_be_out    (mem_be_out),
        .mem_addr_out  (mem_addr_out),
        .mem_wdata_out (mem_wdata_out),
        .mem_ack_in    (mem_ack_in),
        .mem_rdata_in  (mem_rdata_in),
        .err_out       (err_out)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: owner 0 = none, 1 = MEM stage, 2 = IF stage.
    int            m_owner;
    int            m_wait;
    int            m_streak;
    logic          exp_req, exp_we, exp_idone, exp_ddone, exp_err;
    logic [BW-1:0] exp_be;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_ird, exp_drd;

    // Stimulus controls.
    int ack_mode;   // 0 random, 1 ack on third request cycle, 2 never
    int inst_rate;
    int data_rate;
    bit directed;
    bit dir_store;

    task automatic model_reset();
        m_owner = 0; m_wait = 0; m_streak = 0;
        exp_req = 0; exp_we = 0; exp_be = '0; exp_addr = '0; exp_wdata = '0;
        exp_ird = '0; exp_drd = '0; exp_idone = 0; exp_ddone = 0; exp_err = 0;
    endtask

    task automatic model_step();
        bit ir, dr;
        ir = inst_req_in && !exp_idone;
        dr = data_req_in && !exp_ddone;
        exp_idone = 0;
        exp_ddone = 0;
        if (m_owner == 0) begin
            if (dr && !(m_streak == int'(MAXS) && ir)) begin
                m_owner = 1; exp_req = 1; exp_we = data_we_in;
                exp_be = data_we_in ? data_be_in : {BW{1'b1}};
                exp_addr = data_addr_in; exp_wdata = data_wdata_in;
                m_streak = inst_req_in ? ((m_streak < int'(MAXS)) ? m_streak + 1 : m_streak) : 0;
            end else if (ir) begin
                m_owner = 2; exp_req = 1; exp_we = 0; exp_be = {BW{1'b1}};
                exp_addr = inst_addr_in; m_streak = 0;
            end
        end else if (mem_ack_in || m_wait + 1 == int'(TOUT)) begin
            if (!mem_ack_in) exp_err = 1;
            if (m_owner == 1) begin
                exp_ddone = 1; exp_drd = mem_ack_in ? mem_rdata_in : '0;
            end else begin
                exp_idone = 1; exp_ird = mem_ack_in ? mem_rdata_in : '0;
            end
            exp_req = 0; m_owner = 0; m_wait = 0;
        end else begin
            m_wait++;
        end
    endtask

    task automatic check_outputs();
        check_eq("mem_req", mem_req_out, exp_req);
        check_eq("err", err_out, exp_err);
        check_eq("inst_done", inst_done_out, exp_idone);
        check_eq("data_done", data_done_out, exp_ddone);
        if (exp_req) begin
            check_eq("mem_addr", mem_addr_out, exp_addr);
            check_eq("mem_we", mem_we_out, exp_we);
            check_eq("mem_be", mem_be_out, exp_be);
            if (exp_we) check_eq("mem_wdata", mem_wdata_out, exp_wdata);
        end
        if (exp_idone) check_eq("inst_rdata", inst_rdata_out, exp_ird);
        if (exp_ddone) check_eq("data_rdata", data_rdata_out, exp_drd);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_mem_req"}, mem_req_out, 0);
        check_eq({tag, "_err"}, err_out, 0);
        check_eq({tag, "_dones"}, {inst_done_out, data_done_out}, 0);
        check_eq({tag, "_mem_addr"}, mem_addr_out, 0);
        check_eq({tag, "_mem_ctl"}, {mem_we_out, mem_be_out}, 0);
        check_eq({tag, "_rdata"}, {inst_rdata_out, data_rdata_out}, 0);
    endtask

    function automatic bit roll(input int rate);
        return $urandom_range(0, 99) < rate;
    endfunction

    task automatic new_data_req();
        data_req_in = 1;
        if (directed) begin
            dir_store = ~dir_store;
            data_we_in = dir_store;
            data_be_in = 4'b0011;
            data_addr_in = 32'h2000;
            data_wdata_in = 32'hDEAD_BEEF;
        end else begin
            data_we_in = $urandom_range(0, 1);
            data_be_in = BW'($urandom);
            data_addr_in = $urandom;
            data_wdata_in = $urandom;
        end
    endtask

    task automatic drive_inputs();
        if (inst_req_in && exp_idone) begin
            inst_req_in = roll(inst_rate);
            inst_addr_in = directed ? 32'h100 : $urandom;
        end else if (!inst_req_in) begin
            if (roll(inst_rate)) begin
                inst_req_in = 1;
                inst_addr_in = directed ? 32'h100 : $urandom;
            end
        end else if (m_owner == 2) begin
            inst_addr_in = $urandom;
        end

        if (data_req_in && exp_ddone) begin
            data_req_in = 0;
            if (roll(data_rate)) new_data_req();
        end else if (!data_req_in) begin
            if (roll(data_rate)) new_data_req();
        end else if (m_owner == 1) begin
            data_we_in = $urandom_range(0, 1);
            data_be_in = BW'($urandom);
            data_addr_in = $urandom;
            data_wdata_in = $urandom;
        end

        mem_rdata_in = $urandom;
        unique case (ack_mode)
            0: mem_ack_in = roll(30);
            1: mem_ack_in = exp_req && (m_wait == 2);
            default: mem_ack_in = 0;
        endcase
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        drive_inputs();
        #1;
        check_eq("inst_stall", inst_stall_out, inst_req_in & ~exp_idone);
        check_eq("data_stall", data_stall_out, data_req_in & ~exp_ddone);
        model_step();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        bit found;
        model_reset();
        directed = 1; dir_store = 0; ack_mode = 1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1;

        // Lone fetches, then continuous collision of loads/stores with fetches.
        inst_rate = 100; data_rate = 0;
        run(12);
        data_rate = 100;
        run(60);

        directed = 0; ack_mode = 0; inst_rate = 50; data_rate = 50;
        run(1500);

        // Memory never answers: every transaction must time out.
        ack_mode = 2; inst_rate = 70; data_rate = 70;
        run(60);
        ack_mode = 0;
        run(300);

        // Asynchronous reset while a data transaction is outstanding.
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            cycle();
            if (m_owner == 1) found = 1;
        end
        check_eq("reset_window", found, 1);
        if (found) begin
            @(posedge clk);
            #2;
            check_eq("pre_reset_req", mem_req_out, 1);
            rst_n = 0;
            inst_req_in = 0; data_req_in = 0; mem_ack_in = 0;
            #1;
            check_reset_outputs("midreset");
            model_reset();
            repeat (2) @(negedge clk);
            rst_n = 1;
        end
        run(500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
